// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: FSM state codes, ADS1115 pointer values and register reset constants.
package i2c_target_pkg;
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_ADDR     = 4'd1;
  localparam state_t ST_ADDR_ACK = 4'd2;
  localparam state_t ST_PTR      = 4'd3;
  localparam state_t ST_PTR_ACK  = 4'd4;
  localparam state_t ST_WR_DATA  = 4'd5;
  localparam state_t ST_WR_ACK   = 4'd6;
  localparam state_t ST_RD_DATA  = 4'd7;
  localparam state_t ST_RD_ACK   = 4'd8;
  localparam state_t ST_IGNORE   = 4'd9;
  localparam logic [1:0] PTR_CONV = 2'd0;
  localparam logic [1:0] PTR_CFG  = 2'd1;
  localparam logic [1:0] PTR_LO   = 2'd2;
  localparam logic [1:0] PTR_HI   = 2'd3;
  localparam logic [15:0] CFG_RST = 16'h8583;
  localparam logic [15:0] LO_RST  = 16'h8000;
  localparam logic [15:0] HI_RST  = 16'h7FFF;
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: 2-FF synchronizer, optional stability filter (I2C_TARGET_GLITCH_FILTER_EN), edge detect.
module i2c_line_cond #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_lvl;
  // Idle bus level is high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_prev <= w_lvl;
    end
  if (FILT_EN && FILT_LEN > 0) begin : g_filt
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [CW-1:0] r_cnt;
    logic          r_filt;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_cnt  <= '0;
        r_filt <= 1'b1;
      end else if (r_sync[1] == r_filt) r_cnt <= '0;
      else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    assign w_lvl = r_filt;
  end else begin : g_bypass
    assign w_lvl = r_sync[1];
  end
  assign o_level = w_lvl;
  assign o_rise  = w_lvl & ~r_prev;
  assign o_fall  = ~w_lvl & r_prev;
endmodule

// File: rtl/i2c_adc_target.sv
// i2c_adc_target: I2C target emulating the ADS1115 register map; glitch filter via I2C_TARGET_GLITCH_FILTER_EN.
module i2c_adc_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h48,
  parameter int         TX_HOLD     = 10,
  parameter int         FILT_LEN    = 4
) (
  input  logic        clk_50Mhz,
  input  logic        reset_reset_n,
  input  logic        i2c_sda_in,
  input  logic        i2c_scl_in,
  output logic        i2c_sda_oe,
  output logic        i2c_scl_oe,
  input  logic [15:0] conv_data,
  output logic [15:0] cfg_reg,
  output logic [15:0] lo_thresh,
  output logic [15:0] hi_thresh,
  output logic        reg_wr_pulse
);
  localparam int HW = $clog2(TX_HOLD + 1);
  logic w_scl, w_scl_rise, w_scl_fall, w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_drv;
  logic [7:0] w_byte, w_tx;
  logic [15:0] w_rd_reg;
  logic [15:0] w_regs [4];
  state_t r_state;
  logic [2:0] r_bit;
  logic [6:0] r_shift;
  logic [1:0] r_ptr, r_wcnt;
  logic r_rw, r_rd_lsb, r_oe, r_nxt, r_pulse;
  logic [7:0] r_msb;
  logic [15:0] r_shadow, r_cfg, r_lo, r_hi;
  logic [HW-1:0] r_hold;
  i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(clk_50Mhz), .rst_n(reset_reset_n), .i_raw(i2c_scl_in),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));
  i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(clk_50Mhz), .rst_n(reset_reset_n), .i_raw(i2c_sda_in),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall));
  // Gating with our own drive keeps released/driven SDA from faking START/STOP.
  assign w_start = w_scl & w_sda_fall & ~r_oe;
  assign w_stop  = w_scl & w_sda_rise & ~r_oe;
  assign w_byte  = {r_shift, w_sda};
  assign w_regs[PTR_CONV] = r_shadow;
  assign w_regs[PTR_CFG]  = r_cfg;
  assign w_regs[PTR_LO]   = r_lo;
  assign w_regs[PTR_HI]   = r_hi;
  assign w_rd_reg = w_regs[r_ptr];
  assign w_tx     = r_rd_lsb ? w_rd_reg[7:0] : w_rd_reg[15:8];
  assign w_drv = (r_state == ST_ADDR_ACK || r_state == ST_PTR_ACK || r_state == ST_WR_ACK) ? 1'b1 :
                 (r_state == ST_RD_DATA) ? ~w_tx[3'd7 - r_bit] : 1'b0;
  always_ff @(posedge clk_50Mhz or negedge reset_reset_n)
    if (!reset_reset_n) begin
      r_state  <= ST_IDLE;
      r_bit    <= '0;
      r_shift  <= '0;
      r_ptr    <= PTR_CONV;
      r_wcnt   <= '0;
      r_rw     <= 1'b0;
      r_rd_lsb <= 1'b0;
      r_oe     <= 1'b0;
      r_nxt    <= 1'b0;
      r_pulse  <= 1'b0;
      r_msb    <= '0;
      r_shadow <= '0;
      r_cfg    <= CFG_RST;
      r_lo     <= LO_RST;
      r_hi     <= HI_RST;
      r_hold   <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (w_start || w_stop) begin
        r_state <= w_start ? ST_ADDR : ST_IDLE;
        r_bit   <= '0;
        r_oe    <= 1'b0;
        r_hold  <= '0;
      end else begin
        // Each SCL fall schedules the SDA level for the coming bit, applied TX_HOLD cycles later.
        if (w_scl_fall && r_state != ST_IDLE && r_state != ST_IGNORE) begin
          r_hold <= HW'(TX_HOLD);
          r_nxt  <= w_drv;
        end else if (r_hold != '0) begin
          r_hold <= r_hold - 1'b1;
          if (r_hold == HW'(1)) r_oe <= r_nxt;
        end
        if (w_scl_rise)
          case (r_state)
            ST_ADDR: begin
              r_shift <= w_byte[6:0];
              r_bit   <= r_bit + 1'b1;
              if (r_bit == 3'd7) begin
                r_state <= (w_byte[7:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                r_rw     <= w_byte[0];
                r_rd_lsb <= 1'b0;
                if (w_byte[7:1] == TARGET_ADDR && w_byte[0]) r_shadow <= conv_data;
              end
            end
            ST_ADDR_ACK: r_state <= r_rw ? ST_RD_DATA : ST_PTR;
            ST_PTR: begin
              r_shift <= w_byte[6:0];
              r_bit   <= r_bit + 1'b1;
              if (r_bit == 3'd7) begin
                r_state <= ST_PTR_ACK;
                r_ptr   <= w_byte[1:0];
                r_wcnt  <= '0;
              end
            end
            ST_PTR_ACK: r_state <= ST_WR_DATA;
            ST_WR_DATA: begin
              r_shift <= w_byte[6:0];
              r_bit   <= r_bit + 1'b1;
              if (r_bit == 3'd7) begin
                r_state <= ST_WR_ACK;
                r_wcnt  <= (r_wcnt == 2'd2) ? r_wcnt : r_wcnt + 1'b1;
                if (r_wcnt == 2'd0) r_msb <= w_byte;
                if (r_wcnt == 2'd1 && r_ptr != PTR_CONV) begin
                  r_cfg   <= (r_ptr == PTR_CFG) ? {r_msb, w_byte} : r_cfg;
                  r_lo    <= (r_ptr == PTR_LO) ? {r_msb, w_byte} : r_lo;
                  r_hi    <= (r_ptr == PTR_HI) ? {r_msb, w_byte} : r_hi;
                  r_pulse <= 1'b1;
                end
              end
            end
            ST_WR_ACK: r_state <= ST_WR_DATA;
            ST_RD_DATA: begin
              r_bit <= r_bit + 1'b1;
              if (r_bit == 3'd7) r_state <= ST_RD_ACK;
            end
            ST_RD_ACK: begin
              r_state  <= w_sda ? ST_IGNORE : ST_RD_DATA;
              r_rd_lsb <= w_sda ? r_rd_lsb : ~r_rd_lsb;
            end
            default: ;
          endcase
      end
    end
  assign i2c_sda_oe   = r_oe;
  assign i2c_scl_oe   = 1'b0;
  assign cfg_reg      = r_cfg;
  assign lo_thresh    = r_lo;
  assign hi_thresh    = r_hi;
  assign reg_wr_pulse = r_pulse;
endmodule

// File: tb/tb_i2c_adc_target.sv
// tb_i2c_adc_target: directed I2C master with a scoreboard of expected ACK levels and read bytes.
`timescale 1ns/1ps
module tb_i2c_adc_target;
  localparam int Q = 400;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;
  logic sda_in, sda_oe, scl_oe, pulse;
  logic [15:0] conv = 16'h0000;
  logic [15:0] cfg, lo, hi;
  logic [15:0] exp_q[$];
  logic [7:0] d;
  int n_chk = 0, n_err = 0;
  int pulse_cnt = 0, oe_cnt = 0, base;
  assign sda_in = m_sda & ~sda_oe;
  always #10 clk = ~clk;
  i2c_adc_target dut (
    .clk_50Mhz(clk), .reset_reset_n(rst_n), .i2c_sda_in(sda_in), .i2c_scl_in(m_scl),
    .i2c_sda_oe(sda_oe), .i2c_scl_oe(scl_oe), .conv_data(conv),
    .cfg_reg(cfg), .lo_thresh(lo), .hi_thresh(hi), .reg_wr_pulse(pulse));
  always @(negedge clk) begin
    if (pulse) pulse_cnt++;
    if (sda_oe) oe_cnt++;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic sb_chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask
  task automatic bus_bit(input logic b, output logic r);
    m_sda = b;
    #Q m_scl = 1'b1;
    #Q r = sda_in;
    #Q m_scl = 1'b0;
    #Q;
  endtask
  task automatic i2c_start();
    m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
    #Q;
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask
  task automatic wr_byte(input logic [7:0] b, input logic ack, input string tag);
    logic r;
    exp_q.push_back(ack ? 16'h0 : 16'h1);
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    sb_chk(tag, {15'b0, r});
  endtask
  task automatic rd_byte(input logic mack, output logic [7:0] v);
    logic r;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      v = {v[6:0], r};
    end
    bus_bit(~mack, r);
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_cfg", cfg, 16'h8583);
    chk("rst_lo", lo, 16'h8000);
    chk("rst_hi", hi, 16'h7FFF);
    chk("rst_sda_oe", {15'b0, sda_oe}, 16'h0);
    chk("rst_scl_oe", {15'b0, scl_oe}, 16'h0);
    chk("rst_pulse", {15'b0, pulse}, 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // config write
    base = pulse_cnt;
    i2c_start();
    wr_byte(8'h90, 1'b1, "w1_addr_ack");
    wr_byte(8'h01, 1'b1, "w1_ptr_ack");
    wr_byte(8'h84, 1'b1, "w1_msb_ack");
    wr_byte(8'h83, 1'b1, "w1_lsb_ack");
    i2c_stop();
    chk("w1_cfg", cfg, 16'h8483);
    chk("w1_pulses", 16'(pulse_cnt - base), 16'd1);
    // conversion read through repeated start
    conv = 16'h1234;
    i2c_start();
    wr_byte(8'h90, 1'b1, "r1_waddr_ack");
    wr_byte(8'h00, 1'b1, "r1_ptr_ack");
    i2c_start();
    wr_byte(8'h91, 1'b1, "r1_raddr_ack");
    conv = 16'hBEEF;
    exp_q.push_back(16'h12);
    rd_byte(1'b1, d);
    sb_chk("r1_msb", {8'h0, d});
    exp_q.push_back(16'h34);
    rd_byte(1'b0, d);
    sb_chk("r1_lsb", {8'h0, d});
    base = oe_cnt;
    repeat (40) @(negedge clk);
    chk("r1_release", 16'(oe_cnt - base), 16'd0);
    i2c_stop();
    // wrong address
    base = oe_cnt;
    i2c_start();
    wr_byte(8'h92, 1'b0, "bad_addr_nack");
    wr_byte(8'h01, 1'b0, "bad_ignore_nack");
    i2c_stop();
    chk("bad_no_drive", 16'(oe_cnt - base), 16'd0);
    chk("bad_cfg", cfg, 16'h8483);
    chk("bad_hi", hi, 16'h7FFF);
    // MSB-only write is discarded
    base = pulse_cnt;
    i2c_start();
    wr_byte(8'h90, 1'b1, "p_addr_ack");
    wr_byte(8'h03, 1'b1, "p_ptr_ack");
    wr_byte(8'h55, 1'b1, "p_msb_ack");
    i2c_stop();
    chk("p_hi", hi, 16'h7FFF);
    chk("p_pulses", 16'(pulse_cnt - base), 16'd0);
    // repeated reads of pointer 2
    i2c_start();
    wr_byte(8'h90, 1'b1, "r2_waddr_ack");
    wr_byte(8'h02, 1'b1, "r2_ptr_ack");
    i2c_stop();
    i2c_start();
    wr_byte(8'h91, 1'b1, "r2_raddr_ack");
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i[0] ? 16'h00 : 16'h80);
      rd_byte(1'b1, d);
      sb_chk("r2_byte", {8'h0, d});
    end
    i2c_stop();
    // asynchronous reset while the target pulls SDA low
    conv = 16'h0000;
    i2c_start();
    wr_byte(8'h90, 1'b1, "x_waddr_ack");
    wr_byte(8'h00, 1'b1, "x_ptr_ack");
    i2c_start();
    wr_byte(8'h91, 1'b1, "x_raddr_ack");
    for (int i = 0; i < 100 && !sda_oe; i++) @(negedge clk);
    chk("x_drive_low", {15'b0, sda_oe}, 16'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("x_async_release", {15'b0, sda_oe}, 16'h0);
    chk("x_cfg", cfg, 16'h8583);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    i2c_stop();
    base = pulse_cnt;
    i2c_start();
    wr_byte(8'h90, 1'b1, "y_addr_ack");
    wr_byte(8'h02, 1'b1, "y_ptr_ack");
    wr_byte(8'h12, 1'b1, "y_msb_ack");
    wr_byte(8'h34, 1'b1, "y_lsb_ack");
    i2c_stop();
    chk("y_lo", lo, 16'h1234);
    chk("y_pulses", 16'(pulse_cnt - base), 16'd1);
    i2c_start();
    wr_byte(8'h91, 1'b1, "y_raddr_ack");
    exp_q.push_back(16'h12);
    rd_byte(1'b1, d);
    sb_chk("y_rd_msb", {8'h0, d});
    exp_q.push_back(16'h34);
    rd_byte(1'b0, d);
    sb_chk("y_rd_lsb", {8'h0, d});
    i2c_stop();
    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
